fp_sub_iter: RTL
================

// Module: fp_sub_iter
// PURPOSE
//  Multi-cycle single-precision subtractor: s = a - b on the magnitudes of a and b.
//  Companion to the FP adder in the ALU FPA path; it covers the subtract direction
//  that the adder cannot do.
//  Cancellation needs left-normalisation, done here one bit per cycle by an FSM.
//  Handshaked input/output so the ALU sequencer can stall it.
// PARAMETERS
//  EXP_W   8   exponent field width
//  FRAC_W  23  fraction field width (mantissa = FRAC_W+1 with hidden 1)
// PORTS
//  clk        in   1                 clock, rising edge
//  reset_n    in   1                 async active-low reset
//  in_valid   in   1                 a/b valid
//  in_ready   out  1                 block can accept a/b
//  a          in   1+EXP_W+FRAC_W    minuend (sign bit ignored)
//  b          in   1+EXP_W+FRAC_W    subtrahend (sign bit ignored)
//  out_valid  out  1                 s valid
//  out_ready  in   1                 consumer takes s
//  s          out  1+EXP_W+FRAC_W    result {sign, exp, fract}
// BEHAVIOUR
//  Reset (reset_n low, async):
//   - state=IDLE; in_ready=1; out_valid=0; s=0; all internal regs=0.
//  Operand format:
//   - Inputs are treated as normal and positive: mant = {1'b1, fract}.
//   - No NaN/Inf/denormal handling.
//   - Truncation only; no guard/round/sticky bits.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: capture a and b -> ALIGN.
//  ALIGN (1 cycle):
//   - Compare exponents, then mantissas if the exponents are equal.
//   - Larger magnitude is L; sign=1 iff |b|>|a|.
//   - exp=exp(L); shamt=|expa-expb|.
//   - Smaller mantissa >> shamt; forced to 0 when shamt>=24.
//  SUB (1 cycle):
//   - diff = mantL - mantS_shifted (24 bit, never negative) -> NORM.
//  NORM (one decision per cycle):
//   - diff==0 -> s=32'h0 (sign 0) -> DONE.
//   - diff[23]==1 -> s={sign, exp, diff[22:0]} -> DONE.
//   - else if exp==1 -> flush: s=32'h0 -> DONE.
//   - else diff<<=1, exp-=1, stay in NORM.
//  DONE:
//   - out_valid=1; s held stable.
//   - On out_ready: out_valid=0 -> IDLE.
//   - No new operand is accepted before that.
//  Latency and throughput:
//   - out_valid rises 3+k cycles after the input handshake.
//   - k = number of left shifts, 0..23.
//   - One operation in flight; in_ready=0 in every state except IDLE.
//  Edge and error cases:
//   - out_ready held low: DONE persists indefinitely, s unchanged.
//   - reset_n low mid-operation: abort immediately to reset values.
//     No partial output is ever presented.
//   - in_valid while busy is ignored; the source must hold in_valid until in_ready.
// TESTING
//  - a=32'h40400000 (3.0), b=32'h3F800000 (1.0)
//      -> s=32'h40000000, k=0, out_valid 3 cycles after handshake.
//  - a=32'h3F800000, b=32'h40400000
//      -> s=32'hC0000000 (sign set, magnitude 2.0).
//  - a=b=32'h3F800000
//      -> s=32'h00000000, latency 3.
//  - a=32'h3F800000, b=32'h3F7FFFFF (shifted lsb truncated, diff=1)
//      -> s=32'h34000000, k=23, latency 26.
//  - a=32'h4B800000, b=32'h3F800000 (shamt=24 -> shifted mant 0)
//      -> s=32'h4B800000.
//  - a=32'h00800001, b=32'h00800000 (exp underflow) -> s=32'h00000000.
//      Then hold out_ready=0 for 5 cycles: s and out_valid stable, in_ready=0.
//      Then pulse reset_n low during NORM of a new op: out_valid=0, in_ready=1 at once.

Source files
------------

// File: rtl/fp_sub_iter.sv
// fp_sub_iter: multi-cycle magnitude subtractor, s = |a| - |b|, single precision.
// Operands are treated as positive normals ({1, fract}); truncating, no rounding,
// no NaN/Inf/denormal handling. Cancellation is left-normalised one bit per cycle.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (a, b); in_ready only in IDLE
//   a, b                  minuend / subtrahend {sign(ignored), exp, fract}
//   out_valid / out_ready result handshake; s held stable while out_valid
//   s                     result {sign, exp, fract}, sign=1 iff |b| > |a|
module fp_sub_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   s
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] SH_LIM = MANT_W[EXP_W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [W-2:0]        a_q, a_d, b_q, b_d;        // sign bits not stored
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [MANT_W-1:0]   mant_l_q, mant_l_d;
  logic [MANT_W-1:0]   mant_s_q, mant_s_d;
  logic [MANT_W-1:0]   diff_q, diff_d;
  logic [W-1:0]        s_q, s_d;

  // Operand sign bits play no part in the magnitude subtract.
  logic sign_unused;
  assign sign_unused = a[W-1] ^ b[W-1];

  // Alignment terms, evaluated from the captured operands.
  logic [EXP_W-1:0]  exp_a, exp_b, shamt;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              b_gt_a;
  logic [MANT_W-1:0] mant_sm, mant_sm_sh;

  always_comb begin
    exp_a  = a_q[W-2:FRAC_W];
    exp_b  = b_q[W-2:FRAC_W];
    frac_a = a_q[FRAC_W-1:0];
    frac_b = b_q[FRAC_W-1:0];
    // Equal exponents fall back to fraction compare; equal magnitudes give sign 0.
    b_gt_a = (exp_b > exp_a) || ((exp_b == exp_a) && (frac_b > frac_a));
    shamt  = b_gt_a ? (exp_b - exp_a) : (exp_a - exp_b);
    mant_sm = b_gt_a ? {1'b1, frac_a} : {1'b1, frac_b};
    // Everything shifts out once shamt reaches the mantissa width.
    mant_sm_sh = (shamt >= SH_LIM) ? '0 : (mant_sm >> shamt);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_l_d = mant_l_q;
    mant_s_d = mant_s_q;
    diff_d   = diff_q;
    s_d      = s_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a[W-2:0];
          b_d     = b[W-2:0];
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d   = b_gt_a;
        exp_d    = b_gt_a ? exp_b : exp_a;
        mant_l_d = b_gt_a ? {1'b1, frac_b} : {1'b1, frac_a};
        mant_s_d = mant_sm_sh;
        state_d  = S_SUB;
      end
      S_SUB: begin
        diff_d  = mant_l_q - mant_s_q;   // larger minus smaller: never negative
        state_d = S_NORM;
      end
      S_NORM: begin
        if (diff_q == '0) begin
          s_d     = '0;
          state_d = S_DONE;
        end else if (diff_q[MANT_W-1]) begin
          s_d     = {sign_q, exp_q, diff_q[FRAC_W-1:0]};
          state_d = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          // One more shift would leave the normal range: flush to zero.
          s_d     = '0;
          state_d = S_DONE;
        end else begin
          diff_d = diff_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_l_q <= '0;
      mant_s_q <= '0;
      diff_q   <= '0;
      s_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_l_q <= mant_l_d;
      mant_s_q <= mant_s_d;
      diff_q   <= diff_d;
      s_q      <= s_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign s         = s_q;

endmodule
